// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO. Frames go out back-to-back while words are queued.
// txd, busy, tx_done and in_ready are registers, loaded from the next-cycle state.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        txd,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;

    txState_t             state, stateNext;
    logic [BAUD_W-1:0]    baudCnt, baudNext;
    logic [BIT_W-1:0]     bitCnt, bitNext;
    logic [DATA_BITS-1:0] shiftReg, shiftNext;
    logic                 parityBit, parityNext;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr, rdPtr;
    logic [CNT_W-1:0]     count, countNext;
    logic                 txdNext, busyNext, doneNext, readyNext;
    logic                 pushC, popC, baudWrapC;

    assign pushC      = in_valid && in_ready;
    assign baudWrapC  = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign countNext  = count + CNT_W'(pushC) - CNT_W'(popC);
    assign fifo_count = count;

    // Frame sequencer: START, DATA, optional PARITY, STOP; pops the next word on the last stop cycle.
    always_comb begin
        stateNext  = state;
        baudNext   = baudCnt;
        bitNext    = bitCnt;
        shiftNext  = shiftReg;
        parityNext = parityBit;
        popC       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    popC      = 1'b1;
                    baudNext  = '0;
                    bitNext   = '0;
                    stateNext = START;
                end
            end
            START: begin
                if (baudWrapC) begin
                    baudNext  = '0;
                    bitNext   = '0;
                    stateNext = DATA;
                end else begin
                    baudNext = baudCnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baudWrapC) begin
                    baudNext  = '0;
                    shiftNext = shiftReg >> 1;
                    if (bitCnt == BIT_W'(DATA_BITS - 1)) begin
                        bitNext   = '0;
                        stateNext = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitNext = bitCnt + BIT_W'(1);
                    end
                end else begin
                    baudNext = baudCnt + BAUD_W'(1);
                end
            end
            PARITY: begin
                if (baudWrapC) begin
                    baudNext  = '0;
                    bitNext   = '0;
                    stateNext = STOP;
                end else begin
                    baudNext = baudCnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baudWrapC) begin
                    baudNext = '0;
                    if (bitCnt == BIT_W'(STOP_BITS - 1)) begin
                        bitNext = '0;
                        if (count != '0) begin
                            popC      = 1'b1;
                            stateNext = START;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        bitNext = bitCnt + BIT_W'(1);
                    end
                end else begin
                    baudNext = baudCnt + BAUD_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
        // Parity is taken at load time because the shifter destroys the word as it goes out.
        if (popC) begin
            shiftNext  = mem[rdPtr];
            parityNext = (^mem[rdPtr]) ^ 1'(PARITY_ODD);
        end
    end

    // Output levels for the upcoming cycle, so the registered outputs line up with the state.
    always_comb begin
        txdNext = 1'b1;
        case (stateNext)
            START:   txdNext = 1'b0;
            DATA:    txdNext = shiftNext[0];
            PARITY:  txdNext = parityNext;
            default: txdNext = 1'b1;
        endcase
        doneNext  = (stateNext == STOP) && (baudNext == BAUD_W'(CLKS_PER_BIT - 1))
                    && (bitNext == BIT_W'(STOP_BITS - 1));
        busyNext  = (stateNext != IDLE) || (countNext != '0);
        readyNext = (countNext != CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= stateNext;
            baudCnt   <= baudNext;
            bitCnt    <= bitNext;
            shiftReg  <= shiftNext;
            parityBit <= parityNext;
            count     <= countNext;
            txd       <= txdNext;
            busy      <= busyNext;
            tx_done   <= doneNext;
            in_ready  <= readyNext;
            if (pushC) wrPtr <= wrPtr + PTR_W'(1);
            if (popC)  rdPtr <= rdPtr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (pushC) mem[wrPtr] <= in_data;
    end
endmodule
